// File: rtl/spi_host_master.sv
// rtl/spi_host_master.sv - command-driven SPI master for an SPI slave/RAM wrapper
// Purpose: serialises 10-bit command frames MSB first on MOSI under SS_n and,
//          for read-data frames, collects one byte from MISO after a turnaround.
// Ports:
//   clk                 system clock (shared with the slave), rising edge
//   rst                 synchronous active-high reset
//   cmd_valid/cmd_ready host command handshake; cmd_data = {opcode[1:0], byte}
//   rsp_valid/rsp_data  one-cycle read response; rsp_data held until next response
//   busy                master is not idle
//   SS_n, MOSI, MISO    SPI pins towards the slave
module spi_host_master #(
    parameter int TURNAROUND = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);
    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, TURN, RECV, RESP, GAP} state_t;

    localparam int WAIT_W = 16;
    // The IDLE cycle that accepts the next command is the last SS_n-high cycle
    // between frames, so GAP only covers the rest; RESP is the first one of a
    // read-data frame's gap.
    localparam int GAP_WR = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam int GAP_RD = (GAP_CYCLES > 2) ? GAP_CYCLES - 2 : 0;
    localparam logic [WAIT_W-1:0] TURN_LOAD   = WAIT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [WAIT_W-1:0] GAP_WR_LOAD = WAIT_W'((GAP_WR > 0) ? GAP_WR - 1 : 0);
    localparam logic [WAIT_W-1:0] GAP_RD_LOAD = WAIT_W'((GAP_RD > 0) ? GAP_RD - 1 : 0);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [9:0]          cmd_q, cmd_d;
    logic [6:0]          rx_q, rx_d;
    logic [7:0]          rsp_q, rsp_d;
    logic                ready_q;
    logic [9:0]          tx_shifted;

    assign tx_shifted = cmd_q << cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wait_q  <= '0;
            cmd_q   <= 10'd0;
            rx_q    <= 7'd0;
            rsp_q   <= 8'd0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            cmd_q   <= cmd_d;
            rx_q    <= rx_d;
            rsp_q   <= rsp_d;
            // Ready is registered so it stays low for the whole reset period.
            ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        cmd_d   = cmd_q;
        rx_d    = rx_q;
        rsp_d   = rsp_q;
        SS_n    = 1'b1;
        MOSI    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid && ready_q) begin
                    cmd_d   = cmd_data;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                SS_n    = 1'b0;
                MOSI    = cmd_q[9];
                cnt_d   = 4'd0;
                state_d = SHIFT;
            end
            SHIFT: begin
                SS_n = 1'b0;
                MOSI = tx_shifted[9];
                if (cnt_q == 4'd9) begin
                    cnt_d = 4'd0;
                    if (cmd_q[9:8] == 2'b11) begin
                        if (TURNAROUND == 0) begin
                            state_d = RECV;
                        end else begin
                            wait_d  = TURN_LOAD;
                            state_d = TURN;
                        end
                    end else if (GAP_WR == 0) begin
                        state_d = IDLE;
                    end else begin
                        wait_d  = GAP_WR_LOAD;
                        state_d = GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            TURN: begin
                SS_n = 1'b0;
                if (wait_q == '0) begin
                    state_d = RECV;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            RECV: begin
                SS_n = 1'b0;
                rx_d = {rx_q[5:0], MISO};
                if (cnt_q == 4'd7) begin
                    rsp_d   = {rx_q, MISO};
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (GAP_RD == 0) begin
                    state_d = IDLE;
                end else begin
                    wait_d  = GAP_RD_LOAD;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (wait_q == '0) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_spi_host_master.sv
// tb/tb_spi_host_master.sv - randomized model-checked bench for spi_host_master
module tb_spi_host_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       ss_n;
        logic       mosi;
        logic       busy;
        logic       rsp_valid;
        logic [7:0] rsp_data;
        logic       ready;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int TA  = (g == 0) ? 2 : (g == 1) ? 0 : 3;
        localparam int GAP = (g == 0) ? 1 : (g == 1) ? 3 : 2;

        logic       rst = 1'b1;
        logic       cmd_valid = 1'b0;
        logic [9:0] cmd_data = 10'd0;
        logic       cmd_ready, rsp_valid, busy, ss_n, mosi;
        logic       miso = 1'b0;
        logic [7:0] rsp_data;
        logic       fin = 1'b0;
        logic       chk_en = 1'b0;

        spi_host_master #(.TURNAROUND(TA), .GAP_CYCLES(GAP)) dut (
            .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
            .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
            .busy(busy), .SS_n(ss_n), .MOSI(mosi), .MISO(miso)
        );

        // Stub slave/RAM wrapper: decodes frames from SS_n/MOSI, returns RAM data
        // on MISO during the receive window and noise everywhere else.
        logic [7:0] sram [256];
        logic [7:0] s_addr = 8'h00;
        logic [9:0] s_sh = 10'd0;
        int         s_lc = 0;
        initial for (int i = 0; i < 256; i++) sram[i] = 8'h00;
        always @(negedge clk) begin
            logic [7:0] b;
            int k;
            if (!ss_n) begin
                if (s_lc >= 1 && s_lc <= 10) s_sh = {s_sh[8:0], mosi};
                k = s_lc - 11 - TA;
                b = sram[s_addr];
                if (s_sh[9:8] == 2'b11 && s_lc >= 11 && k >= 0 && k < 8) miso = b[7-k];
                else miso = 1'($urandom);
                s_lc++;
            end else begin
                if (s_lc == 11) begin
                    if (s_sh[9:8] == 2'b01) sram[s_addr] = s_sh[7:0];
                    else s_addr = s_sh[7:0];
                end
                s_lc = 0;
                miso = 1'($urandom);
            end
        end

        // Reference model: on acceptance the whole frame is expanded into a
        // list of expected per-cycle outputs; an empty list means idle.
        exp_t       q[$];
        logic       m_rdy = 1'b0;
        logic [7:0] m_last = 8'h00;
        logic [7:0] m_addr = 8'h00;
        logic [7:0] m_ram [logic [7:0]];
        int         n_rsp = 0;

        function automatic exp_t rec(input logic s, input logic m, input logic v, input logic [7:0] d);
            exp_t r;
            r.ss_n = s; r.mosi = m; r.busy = 1'b1; r.rsp_valid = v; r.rsp_data = d; r.ready = 1'b0;
            return r;
        endfunction

        task automatic push_frame(input logic [9:0] c);
            logic [7:0] old, d;
            old = m_last;
            q.push_back(rec(1'b0, c[9], 1'b0, old));
            for (int i = 9; i >= 0; i--) q.push_back(rec(1'b0, c[i], 1'b0, old));
            case (c[9:8])
                2'b00, 2'b10: m_addr = c[7:0];
                2'b01:        m_ram[m_addr] = c[7:0];
                default:      ;
            endcase
            if (c[9:8] != 2'b11) begin
                for (int i = 1; i < GAP; i++) q.push_back(rec(1'b1, 1'b0, 1'b0, old));
            end else begin
                d = m_ram.exists(m_addr) ? m_ram[m_addr] : 8'h00;
                for (int i = 0; i < TA + 8; i++) q.push_back(rec(1'b0, 1'b0, 1'b0, old));
                q.push_back(rec(1'b1, 1'b0, 1'b1, d));
                for (int i = 2; i < GAP; i++) q.push_back(rec(1'b1, 1'b0, 1'b0, d));
                m_last = d;
            end
        endtask

        always @(posedge clk) begin
            if (rst) begin
                q.delete();
                m_rdy  = 1'b0;
                m_last = 8'h00;
            end else if (q.size() > 0) begin
                void'(q.pop_front());
                m_rdy = (q.size() == 0);
            end else if (m_rdy && cmd_valid) begin
                push_frame(cmd_data);
                m_rdy = 1'b0;
            end else begin
                m_rdy = 1'b1;
            end
        end

        always @(negedge clk) begin
            exp_t e, a;
            if (chk_en) begin
                if (q.size() > 0) e = q[0];
                else begin
                    e.ss_n = 1'b1; e.mosi = 1'b0; e.busy = 1'b0; e.rsp_valid = 1'b0;
                    e.rsp_data = m_last; e.ready = m_rdy;
                end
                a.ss_n = ss_n; a.mosi = mosi; a.busy = busy; a.rsp_valid = rsp_valid;
                a.rsp_data = rsp_data; a.ready = cmd_ready;
                check($sformatf("cfg%0d outputs{ss_n,mosi,busy,rsp_valid,rsp_data,ready} t=%0t", g, $time),
                      {19'd0, a}, {19'd0, e});
                if (rsp_valid) n_rsp++;
            end
        end

        // Frame log observed on the pins: SS_n-low lengths, MOSI bits, high gaps.
        int          f_len[$];
        logic [31:0] f_bits[$];
        int          gaps[$];
        int          cur_len = 0;
        logic [31:0] cur_bits = 32'd0;
        int          hi_run = 0;
        int          nfr = 0;
        logic        prev_ss = 1'b1;
        always @(negedge clk) begin
            if (chk_en) begin
                if (!ss_n) begin
                    if (prev_ss) begin
                        if (nfr > 0) gaps.push_back(hi_run);
                        cur_len = 0;
                        cur_bits = 32'd0;
                    end
                    cur_len++;
                    cur_bits = {cur_bits[30:0], mosi};
                end else begin
                    if (!prev_ss) begin
                        f_len.push_back(cur_len);
                        f_bits.push_back(cur_bits);
                        nfr++;
                        hi_run = 0;
                    end
                    hi_run++;
                end
                prev_ss = ss_n;
            end
        end

        task automatic send(input logic [9:0] c, input bit keep);
            int t;
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_data  = c;
            t = 0;
            while (!cmd_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) timeout($sformatf("cfg%0d accept", g));
            @(posedge clk);
            if (!keep) begin
                @(negedge clk);
                cmd_valid = 1'b0;
            end
        endtask

        task automatic wait_idle();
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while ((busy || q.size() > 0) && t < 400);
            if (t >= 400) timeout($sformatf("cfg%0d idle", g));
            repeat (2) @(negedge clk);
        endtask

        initial begin
            int f0, g0, r0, t;
            @(posedge clk);
            chk_en = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            check($sformatf("cfg%0d reset ss_n", g), 32'(ss_n), 32'd1);
            check($sformatf("cfg%0d reset mosi", g), 32'(mosi), 32'd0);
            check($sformatf("cfg%0d reset rsp_data", g), 32'(rsp_data), 32'h00);
            check($sformatf("cfg%0d reset rsp_valid", g), 32'(rsp_valid), 32'd0);
            check($sformatf("cfg%0d reset cmd_ready", g), 32'(cmd_ready), 32'd1);

            f0 = f_len.size();
            r0 = n_rsp;
            send(10'b00_0001_0000, 1'b0);
            send(10'b01_1010_0101, 1'b0);
            send(10'b10_0001_0000, 1'b0);
            send(10'b11_0000_0000, 1'b0);
            wait_idle();
            check($sformatf("cfg%0d wr-addr frame length", g), 32'(f_len[f0]), 32'd11);
            check($sformatf("cfg%0d wr-addr MOSI bits", g), f_bits[f0], 32'h010);
            check($sformatf("cfg%0d wr-data frame length", g), 32'(f_len[f0+1]), 32'd11);
            check($sformatf("cfg%0d RAM[0x10]", g), 32'(sram[8'h10]), 32'hA5);
            check($sformatf("cfg%0d rd-addr frame length", g), 32'(f_len[f0+2]), 32'd11);
            check($sformatf("cfg%0d rd-data frame length", g), 32'(f_len[f0+3]), 32'(19 + TA));
            check($sformatf("cfg%0d read pulses", g), 32'(n_rsp - r0), 32'd1);
            check($sformatf("cfg%0d read byte", g), 32'(rsp_data), 32'hA5);

            f0 = f_len.size();
            g0 = gaps.size();
            send(10'b00_0010_0000, 1'b1);
            send({2'b01, 8'($urandom)}, 1'b1);
            send({2'b01, 8'($urandom)}, 1'b1);
            @(negedge clk);
            cmd_valid = 1'b0;
            wait_idle();
            check($sformatf("cfg%0d back-to-back frames", g), 32'(f_len.size() - f0), 32'd3);
            check($sformatf("cfg%0d gap 1", g), 32'(gaps[g0+1]), 32'(GAP));
            check($sformatf("cfg%0d gap 2", g), 32'(gaps[g0+2]), 32'(GAP));

            send(10'b00_0011_0011, 1'b0);
            send(10'b01_0101_1010, 1'b0);
            send(10'b10_0011_0011, 1'b0);
            send(10'b11_0000_0000, 1'b0);
            wait_idle();
            check($sformatf("cfg%0d MISO 0x5A", g), 32'(rsp_data), 32'h5A);

            r0 = n_rsp;
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_data  = 10'b11_0000_0000;
            t = 0;
            while (!cmd_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) timeout($sformatf("cfg%0d abort accept", g));
            @(posedge clk);
            repeat (6) begin
                @(negedge clk);
                cmd_valid = 1'b0;
            end
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check($sformatf("cfg%0d abort ss_n", g), 32'(ss_n), 32'd1);
            check($sformatf("cfg%0d abort rsp_data cleared", g), 32'(rsp_data), 32'h00);
            wait_idle();
            check($sformatf("cfg%0d abort no pulse", g), 32'(n_rsp - r0), 32'd0);
            send(10'b11_0000_0000, 1'b0);
            wait_idle();
            check($sformatf("cfg%0d after abort read", g), 32'(rsp_data), 32'h5A);
            check($sformatf("cfg%0d after abort pulses", g), 32'(n_rsp - r0), 32'd1);

            for (int i = 0; i < 40; i++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                send({2'($urandom), 8'($urandom_range(0, 7))}, 1'($urandom));
            end
            @(negedge clk);
            cmd_valid = 1'b0;
            wait_idle();
            fin = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60000) timeout("overall run");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_host_master.md
SPI_HOST_MASTER -- requirements
Module: spi_host_master

Interface
REQ-001 Parameter TURNAROUND, default 2: SS_n-low cycles between the last read-data command bit and the first MISO sample.
REQ-002 Parameter GAP_CYCLES, default 1: minimum SS_n-high cycles between frames.
REQ-003 clk  input  1  single system clock; all logic on its rising edge; the same clock drives the downstream SPI slave/RAM wrapper.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  host command request.
REQ-006 cmd_ready  output  1  master can accept a command this cycle.
REQ-007 cmd_data  input  10  frame payload; [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] address/data.
REQ-008 rsp_valid  output  1  one-cycle pulse: rsp_data holds a completed read.
REQ-009 rsp_data  output  8  byte received on MISO.
REQ-010 busy  output  1  high whenever the master is not in IDLE.
REQ-011 SS_n  output  1  slave select to the slave, active-low.
REQ-012 MOSI  output  1  serial data to the slave.
REQ-013 MISO  input  1  serial data from the slave.

Function
REQ-014 The master SHALL implement the states IDLE, SELECT, SHIFT, TURN, RECV, RESP and GAP.
REQ-015 cmd_ready SHALL equal 1 only in IDLE; a command is accepted on a rising edge with cmd_valid=1 and cmd_ready=1, and cmd_data is latched internally on that edge.
REQ-016 Acceptance SHALL move IDLE->SELECT; in SELECT (1 cycle) SS_n=0 and MOSI=latched bit 9.
REQ-017 SHIFT SHALL last exactly 10 cycles with SS_n=0, driving MOSI with latched bits 9 down to 0 (MSB first), one bit per cycle, using a 4-bit bit counter.
REQ-018 After SHIFT, opcodes 00/01/10 SHALL go to GAP, so SS_n is low for exactly 11 cycles per write/read-address frame.
REQ-019 After SHIFT, opcode 11 SHALL go to TURN for TURNAROUND cycles (SS_n=0, MOSI=0, MISO ignored), then to RECV.
REQ-020 RECV SHALL last 8 cycles with SS_n=0 and MOSI=0, sampling MISO on each rising edge into a shift register, MSB first.
REQ-021 After RECV, the master SHALL spend 1 cycle in RESP with SS_n=1, rsp_valid=1 and rsp_data=received byte, then enter GAP.
REQ-022 rsp_data SHALL hold its value until the next RESP; rsp_valid SHALL NOT be asserted in any other state; the host has no backpressure.
REQ-023 GAP SHALL hold SS_n=1 and MOSI=0 for GAP_CYCLES cycles, then return to IDLE; RESP counts as the first GAP cycle for read-data frames.
REQ-024 cmd_valid SHALL be ignored outside IDLE; a command held across a busy period SHALL be accepted on the first IDLE cycle.
REQ-025 Back-to-back commands SHALL give SS_n high for exactly GAP_CYCLES cycles between frames.
REQ-026 TURNAROUND=0 SHALL go from SHIFT directly to RECV.
REQ-027 All outputs (SS_n, MOSI, cmd_ready, busy, rsp_valid, rsp_data) SHALL be registered or decoded only from the registered state; there SHALL be no combinational path from MISO to any output.

Reset
REQ-028 While rst=1 at a rising edge, the next state SHALL be IDLE with SS_n=1, MOSI=0, rsp_valid=0, rsp_data=8'h00, busy=0, the bit counter at 0 and the latched command cleared.
REQ-029 cmd_ready SHALL be 0 during any cycle in which rst=1, and 1 from the first cycle after rst falls.
REQ-030 Reset asserted mid-frame (any state) SHALL abort the frame: SS_n=1 on the following cycle, no rsp_valid pulse, and no partial frame resumed.

Verification
REQ-031 Reset: rst=1 for 2 cycles, then 0 -> SS_n=1, MOSI=0, rsp_data=00, rsp_valid=0, cmd_ready=1 on the first cycle after release.
REQ-032 Write pair: cmd 10'b00_0001_0000, then 10'b01_1010_0101, with the downstream slave/RAM wrapper attached -> each frame has 11 SS_n-low cycles with MOSI sequence 0,0,0,0,0,0,1,0,0,0,0 (first frame); RAM address 0x10 holds 0xA5.
REQ-033 Read: cmd 10'b10_0001_0000, then 10'b11_0000_0000 -> read-data frame has SS_n low for 1+10+TURNAROUND+8 cycles; exactly one rsp_valid pulse with rsp_data=0xA5.
REQ-034 Back-to-back: cmd_valid held high for 3 commands -> exactly 3 acceptances; SS_n high for exactly GAP_CYCLES cycles between frames; cmd_ready=0 throughout each frame.
REQ-035 Abort: rst=1 at the 5th SHIFT cycle of a read-data frame -> SS_n=1 next cycle, rsp_valid never pulses, and the next command executes normally.
REQ-036 MISO pattern: stub slave drives 0x5A over the 8 RECV cycles with TURNAROUND=0 and TURNAROUND=3 -> rsp_data=0x5A in both cases, with no sampling during TURN.
